// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: access-state encoding and
// default bus geometry.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned DATA_W_DEF   = 20;
    localparam int unsigned MAX_WAIT_DEF = 4;

    // Which requester owns the memory bus in the current cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        F_ACC = 2'b01,
        D_ACC = 2'b10
    } arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive fetch denials. Once the count reaches
// MAX_WAIT, force_f tells the arbiter to let fetch through on its next select.
// Only present in builds with MEM_ARB_STARVE_GUARD_EN defined.
`ifdef MEM_ARB_STARVE_GUARD_EN
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic inc,
    input  logic clr,
    output logic force_f
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count_r;

    // Denial count: clear wins over increment, and the count holds at MAX_CNT.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != MAX_CNT)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign force_f = (count_r == MAX_CNT);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main memory between instruction fetch and the
// MEM-stage data port. One access is granted per cycle, data has priority, and
// read data returns with a one-cycle valid pulse on the edge after the grant.
// Optional build macro: MEM_ARB_STARVE_GUARD_EN adds a fetch starvation guard
// that lets fetch win after MAX_WAIT consecutive denials.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_q
);

    arb_state_e        state_r;
    arb_state_e        next_state_s;
    logic [ADDR_W-1:0] acc_addr_r;
    logic [DATA_W-1:0] acc_wdata_r;
    logic              acc_we_r;
    logic              force_f_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic wait_inc_s;
    logic wait_clr_s;

    // A denial is a cycle where fetch is waiting but data takes the bus.
    assign wait_inc_s = f_req && (next_state_s == D_ACC);
    assign wait_clr_s = (next_state_s == F_ACC) || !f_req;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .Clock   (Clock),
        .Reset   (Reset),
        .inc     (wait_inc_s),
        .clr     (wait_clr_s),
        .force_f (force_f_s)
    );
`else
    logic unused_max_wait_s;

    assign force_f_s         = 1'b0;
    assign unused_max_wait_s = (MAX_WAIT != 32'd0);
`endif

    // Select the next owner: a starved fetch first, then data, then fetch.
    always_comb begin
        next_state_s = IDLE;
        if (f_req && force_f_s) begin
            next_state_s = F_ACC;
        end else if (d_req) begin
            next_state_s = D_ACC;
        end else if (f_req) begin
            next_state_s = F_ACC;
        end else begin
            next_state_s = IDLE;
        end
    end

    // Complete the current access, then register the newly selected one.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= IDLE;
            acc_addr_r  <= {ADDR_W{1'b0}};
            acc_wdata_r <= {DATA_W{1'b0}};
            acc_we_r    <= 1'b0;
            f_rdata     <= {DATA_W{1'b0}};
            f_rvalid    <= 1'b0;
            d_rdata     <= {DATA_W{1'b0}};
            d_rvalid    <= 1'b0;
        end else begin
            // Read data is captured at the end of the granted cycle; a data
            // write leaves d_rdata alone and raises no valid.
            if (state_r == F_ACC) begin
                f_rdata  <= mem_q;
                f_rvalid <= 1'b1;
            end else begin
                f_rvalid <= 1'b0;
            end
            if ((state_r == D_ACC) && !acc_we_r) begin
                d_rdata  <= mem_q;
                d_rvalid <= 1'b1;
            end else begin
                d_rvalid <= 1'b0;
            end

            state_r <= next_state_s;
            case (next_state_s)
                D_ACC: begin
                    acc_addr_r  <= d_addr;
                    acc_wdata_r <= d_wdata;
                    acc_we_r    <= d_we;
                end
                F_ACC: begin
                    acc_addr_r  <= f_addr;
                    acc_wdata_r <= {DATA_W{1'b0}};
                    acc_we_r    <= 1'b0;
                end
                default: begin
                    acc_addr_r  <= acc_addr_r;
                    acc_wdata_r <= acc_wdata_r;
                    acc_we_r    <= acc_we_r;
                end
            endcase
        end
    end

    assign f_gnt = (state_r == F_ACC);
    assign d_gnt = (state_r == D_ACC);

    // Memory bus decoded only from registers so it is settled well before the
    // negedge write point; the bus is parked at zero when idle.
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_data  = {DATA_W{1'b0}};
        mem_wr_en = 1'b0;
        case (state_r)
            F_ACC: begin
                mem_addr = acc_addr_r;
            end
            D_ACC: begin
                mem_addr  = acc_addr_r;
                mem_data  = acc_wdata_r;
                mem_wr_en = acc_we_r;
            end
            default: begin
                mem_addr  = {ADDR_W{1'b0}};
                mem_data  = {DATA_W{1'b0}};
                mem_wr_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 32 x 20 memory
// (combinational read, negedge write) and read-data scoreboards per port.
module tb_mem_port_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        f_req;
    logic [4:0]  f_addr;
    logic        f_gnt;
    logic [19:0] f_rdata;
    logic        f_rvalid;
    logic        d_req;
    logic        d_we;
    logic [4:0]  d_addr;
    logic [19:0] d_wdata;
    logic        d_gnt;
    logic [19:0] d_rdata;
    logic        d_rvalid;
    logic [4:0]  mem_addr;
    logic [19:0] mem_data;
    logic        mem_wr_en;
    logic [19:0] mem_q;

    logic [19:0] mem     [32];
    logic [19:0] ref_mem [32];
    logic [19:0] f_exp_q [$];
    logic [19:0] d_exp_q [$];
    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    // Memory under the arbiter: combinational read, write at negedge.
    assign mem_q = mem[mem_addr];
    always @(negedge Clock) begin
        if (mem_wr_en) mem[mem_addr] <= mem_data;
    end

    mem_port_arbiter dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rdata   (f_rdata),
        .f_rvalid  (f_rvalid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wr_en (mem_wr_en),
        .mem_q     (mem_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and score any returned data.
    task automatic step();
        @(posedge Clock);
        #1;
        if (f_rvalid) begin
            if (f_exp_q.size() == 0) chk("f_rvalid_unexpected", 32'(f_rvalid), 32'd0);
            else chk("f_rdata", 32'(f_rdata), 32'(f_exp_q.pop_front()));
        end
        if (d_rvalid) begin
            if (d_exp_q.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
            else chk("d_rdata", 32'(d_rdata), 32'(d_exp_q.pop_front()));
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_f_gnt"}, 32'(f_gnt), 32'd0);
        chk({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
        chk({tag, "_f_rvalid"}, 32'(f_rvalid), 32'd0);
        chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
        chk({tag, "_mem_wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_f;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 20'(i * 32'h111);
            ref_mem[i] = 20'(i * 32'h111);
        end
        mem[1] = 20'h00003; ref_mem[1] = 20'h00003;

        // Reset dominates both requests.
        Reset = 1'b1; f_req = 1'b1; f_addr = 5'd9;
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd10; d_wdata = 20'h12345;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_quiet("reset");
            chk("reset_f_rdata", 32'(f_rdata), 32'd0);
            chk("reset_d_rdata", 32'(d_rdata), 32'd0);
        end
        chk("reset_no_write", 32'(mem[10]), 32'(ref_mem[10]));
        Reset = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        chk_quiet("idle");

        // Lone fetch from address 1.
        f_req = 1'b1; f_addr = 5'd1; f_exp_q.push_back(ref_mem[1]);
        step();
        chk("fetch_f_gnt", 32'(f_gnt), 32'd1);
        chk("fetch_d_gnt", 32'(d_gnt), 32'd0);
        chk("fetch_mem_addr", 32'(mem_addr), 32'd1);
        chk("fetch_mem_wr_en", 32'(mem_wr_en), 32'd0);
        f_req = 1'b0;
        step();
        chk("fetch_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("fetch_f_gnt_drop", 32'(f_gnt), 32'd0);
        chk("fetch_value", 32'(f_rdata), 32'h00003);

        // Contention: data read wins, fetch follows on the next cycle.
        f_req = 1'b1; f_addr = 5'd2; f_exp_q.push_back(ref_mem[2]);
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd3; d_exp_q.push_back(ref_mem[3]);
        step();
        chk("cont_d_gnt", 32'(d_gnt), 32'd1);
        chk("cont_f_gnt_wait", 32'(f_gnt), 32'd0);
        chk("cont_mem_addr_d", 32'(mem_addr), 32'd3);
        d_req = 1'b0;
        step();
        chk("cont_f_gnt", 32'(f_gnt), 32'd1);
        chk("cont_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("cont_mem_addr_f", 32'(mem_addr), 32'd2);
        f_req = 1'b0;
        step();
        chk("cont_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("cont_d_rvalid_drop", 32'(d_rvalid), 32'd0);

        // Write then read back the same address.
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd7; d_wdata = 20'hABCDE;
        step();
        chk("wr_d_gnt", 32'(d_gnt), 32'd1);
        chk("wr_mem_wr_en", 32'(mem_wr_en), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'd7);
        chk("wr_mem_data", 32'(mem_data), 32'hABCDE);
        ref_mem[7] = 20'hABCDE;
        d_we = 1'b0; d_wdata = 20'h00000; d_exp_q.push_back(ref_mem[7]);
        step();
        chk("rd_d_gnt", 32'(d_gnt), 32'd1);
        chk("rd_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("wr_no_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("wr_mem_updated", 32'(mem[7]), 32'hABCDE);
        d_req = 1'b0;
        step();
        chk("rd_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("rd_value", 32'(d_rdata), 32'hABCDE);
        chk("rd_mem_wr_en_idle", 32'(mem_wr_en), 32'd0);

        // Reset arriving during a write cycle: the write still lands.
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd4; d_wdata = 20'h00055;
        step();
        chk("rstwr_d_gnt", 32'(d_gnt), 32'd1);
        chk("rstwr_mem_wr_en", 32'(mem_wr_en), 32'd1);
        Reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
        step();
        ref_mem[4] = 20'h00055;
        chk("rstwr_mem4", 32'(mem[4]), 32'h00055);
        chk_quiet("rstwr");
        chk("rstwr_d_rdata", 32'(d_rdata), 32'd0);
        Reset = 1'b0;
        d_req = 1'b1; d_addr = 5'd4; d_exp_q.push_back(ref_mem[4]);
        step();
        chk("rstwr_rd_gnt", 32'(d_gnt), 32'd1);
        d_req = 1'b0;
        step();
        chk("rstwr_rd_rvalid", 32'(d_rvalid), 32'd1);

        // Both requests held: strict data priority, or 4 data then 1 fetch.
        f_req = 1'b1; f_addr = 5'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd6;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_f = ((i % 5) == 4);
`else
            exp_f = 1'b0;
`endif
            if (exp_f) f_exp_q.push_back(ref_mem[5]);
            else d_exp_q.push_back(ref_mem[6]);
            step();
            chk("held_f_gnt", 32'(f_gnt), 32'(exp_f));
            chk("held_d_gnt", 32'(d_gnt), 32'(!exp_f));
        end
        f_req = 1'b0; d_req = 1'b0;
        step();
        step();
        chk_quiet("drain");
        chk("f_queue_empty", 32'(f_exp_q.size()), 32'd0);
        chk("d_queue_empty", 32'(d_exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port main memory (32 x 20-bit, combinational read, write on Clock negedge) between the pipeline's instruction-fetch port and data (MEM-stage) port. Registers one winning request per cycle, drives the memory bus for that cycle, and returns captured read data with a valid pulse on the following edge. Sits between the IF/MEM stages and memory_main.

Parameters:
ADDR_W, 5, memory address width
DATA_W, 20, memory word width
MAX_WAIT, 4, consecutive fetch denials before fetch is forced to win (starvation guard only)

Ports:
Clock  input  1  system clock; all state updates on posedge
Reset  input  1  synchronous, active-high reset
f_req  input  1  fetch read request; held until f_gnt
f_addr  input  ADDR_W  fetch address; stable while f_req is high
f_gnt  output  1  fetch access on memory bus this cycle
f_rdata  output  DATA_W  fetch read data
f_rvalid  output  1  one-cycle pulse; f_rdata is valid
d_req  input  1  data request; held until d_gnt
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  write data
d_gnt  output  1  data access on memory bus this cycle
d_rdata  output  DATA_W  data read data
d_rvalid  output  1  one-cycle pulse, reads only
mem_addr  output  ADDR_W  to memory addr
mem_data  output  DATA_W  to memory data
mem_wr_en  output  1  to memory wr_en
mem_q  input  DATA_W  from memory q

Behaviour:
- States: IDLE, F_ACC, D_ACC (registered). Registers: state, acc_addr, acc_wdata, acc_we.
- Each posedge, two steps in order:
  (1) Complete. If state = F_ACC: f_rdata <= mem_q, f_rvalid <= 1. If D_ACC and !acc_we: d_rdata <= mem_q, d_rvalid <= 1. Otherwise the rvalids go to 0.
  (2) Select. If d_req: D_ACC, latch d_addr/d_wdata/d_we. Else if f_req: F_ACC, latch f_addr, acc_we = 0. Else IDLE.
- Data priority: the MEM stage must never stall behind IF.
- Throughput is one access per cycle; back-to-back grants are allowed.
- f_gnt = (state == F_ACC) and d_gnt = (state == D_ACC), both decoded from registered state.
- A requester drops or changes its request the edge after it sees its gnt high.
- Request-to-gnt latency: 1 edge. Gnt-to-rvalid: 1 edge.
- Bus in F_ACC/D_ACC: mem_addr = acc_addr; mem_data = acc_wdata in D_ACC, otherwise 0; mem_wr_en = acc_we in D_ACC only.
- Bus in IDLE: mem_addr = 0, mem_data = 0, mem_wr_en = 0.
- Bus is glitch-free before the negedge write point.
- Writes: memory updates at the negedge inside the D_ACC cycle. d_rdata is unchanged and d_rvalid stays 0.
- Read after write to the same address on the next grant returns the new value.
- Reset: state = IDLE, all acc_* = 0, gnts/rvalids = 0, f_rdata = d_rdata = 0.
- Reset asserted during a D_ACC write cycle: the negedge write still occurs. The completion rvalid is suppressed and state goes to IDLE.
- Reset dominates both requests.
- d_req and f_req high together with no guard: data wins; fetch waits with no penalty.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN
- Defined: a wait counter increments on each edge where f_req is high but D_ACC is selected. It clears when F_ACC is selected or f_req is low. When the count reaches MAX_WAIT, the next select picks fetch even if d_req is high, then the counter clears.
- Undefined: counter absent; strict data priority.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE = 2'b00, F_ACC = 2'b01, D_ACC = 2'b10), default ADDR_W/DATA_W constants.
- Sub-module arb_wait_counter: saturating denial counter with Clock, Reset, inc, clr and force_f output. Instantiated only under the macro.

Test Plan:
- Reset: hold Reset 2 cycles with both reqs high -> all gnt/rvalid 0, mem_wr_en 0, mem_addr 0, rdatas 0.
- Lone fetch: preload Mem[1] = 20'h00003; f_req, f_addr = 1 -> f_gnt the next cycle, then f_rvalid with f_rdata = 20'h00003 one edge later.
- Contention: f_req (addr 2) and d_req read (addr 3) in the same cycle -> d_gnt first, f_gnt the next cycle, d_rvalid then f_rvalid on consecutive edges.
- Write/read: d write addr 7 = 20'hABCDE, then d read addr 7 -> no d_rvalid for the write; the read returns 20'hABCDE; mem_wr_en high only in the write cycle.
- Reset mid-write: Reset in the D_ACC write cycle (addr 4 = 20'h00055) -> Mem[4] = 20'h00055, no rvalid, state IDLE.
- Guard (macro on, MAX_WAIT = 4): d_req and f_req held high continuously -> four d_gnt, then one f_gnt, repeating. With the macro off -> f_gnt never asserts.
